stopwatch_lap_timer: RTL

//   Parametrised BCD stopwatch/countdown timer, successor to the basic hh:mm:ss watch.

---
 rtl/stopwatch_lap_timer.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/stopwatch_lap_timer.sv
// BCD hh:mm:ss stopwatch/countdown timer with tick prescaler, preset load and a lap FIFO.
// Digit carries and borrows ripple through all six digits within a single tick.
module stopwatch_lap_timer #(
    parameter int CLK_DIV   = 50_000_000,
    parameter int HR_MOD    = 24,
    parameter int LAP_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           clear,
    input  logic                           start_stop,
    input  logic                           mode,
    input  logic                           load,
    input  logic [23:0]                    preset,
    input  logic                           lap,
    input  logic                           lap_ready,
    output logic [23:0]                    time_bcd,
    output logic                           running,
    output logic                           done,
    output logic [23:0]                    lap_data,
    output logic                           lap_valid,
    output logic [$clog2(LAP_DEPTH+1)-1:0] lap_count,
    output logic                           lap_ovf
);

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int AW = $clog2(LAP_DEPTH);
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
    localparam logic [7:0] HR_LAST = {4'((HR_MOD - 1) / 10), 4'((HR_MOD - 1) % 10)};
    localparam logic [7:0] MS_LAST = 8'h59;

    // Two-digit BCD step; bit 8 of the result is the carry/borrow into the next pair.
    function automatic logic [8:0] bcd_inc(input logic [7:0] v, input logic [7:0] last);
        if (v == last)          return {1'b1, 8'h00};
        else if (v[3:0] == 4'd9) return {1'b0, v[7:4] + 4'd1, 4'd0};
        else                    return {1'b0, v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [8:0] bcd_dec(input logic [7:0] v, input logic [7:0] last);
        if (v == 8'h00)          return {1'b1, last};
        else if (v[3:0] == 4'd0) return {1'b0, v[7:4] - 4'd1, 4'd9};
        else                     return {1'b0, v[7:4], v[3:0] - 4'd1};
    endfunction

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(LAP_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    logic [PW-1:0] presc;
    logic          mode_r;
    logic          tick;
    logic [8:0]    sec_up, min_up, hr_up, sec_dn, min_dn, hr_dn;
    logic [23:0]   time_up, time_dn;

    assign tick = running && (presc == PRESC_LAST);

    always_comb begin
        sec_up  = bcd_inc(time_bcd[7:0], MS_LAST);
        min_up  = sec_up[8] ? bcd_inc(time_bcd[15:8], MS_LAST) : {1'b0, time_bcd[15:8]};
        hr_up   = min_up[8] ? bcd_inc(time_bcd[23:16], HR_LAST) : {1'b0, time_bcd[23:16]};
        sec_dn  = bcd_dec(time_bcd[7:0], MS_LAST);
        min_dn  = sec_dn[8] ? bcd_dec(time_bcd[15:8], MS_LAST) : {1'b0, time_bcd[15:8]};
        hr_dn   = min_dn[8] ? bcd_dec(time_bcd[23:16], HR_LAST) : {1'b0, time_bcd[23:16]};
        time_up = {hr_up[7:0], min_up[7:0], sec_up[7:0]};
        time_dn = {hr_dn[7:0], min_dn[7:0], sec_dn[7:0]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            time_bcd <= '0;
            running  <= 1'b0;
            done     <= 1'b0;
            presc    <= '0;
            mode_r   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (clear) begin
                time_bcd <= '0;
                presc    <= '0;
                running  <= 1'b0;
            end else if (load && !running) begin
                time_bcd <= preset;
                presc    <= '0;
            end else begin
                if (running)
                    presc <= tick ? '0 : presc + 1'b1;
                if (tick) begin
                    if (mode_r) begin
                        time_bcd <= time_dn;
                        if (time_dn == 24'h0) done <= 1'b1;
                    end else begin
                        time_bcd <= time_up;
                        if (hr_up[8]) done <= 1'b1;
                    end
                end
                // A tick that lands on zero in down mode stops the count on the same edge.
                if (start_stop) begin
                    if (running) begin
                        running <= 1'b0;
                    end else if (!(mode && time_bcd == 24'h0)) begin
                        running <= 1'b1;
                        mode_r  <= mode;
                    end
                end else if (tick && mode_r && time_dn == 24'h0) begin
                    running <= 1'b0;
                end
            end
        end
    end

    logic [23:0]   lap_mem [LAP_DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic          full, do_pop, do_push;

    assign lap_valid = (lap_count != '0);
    assign full      = (lap_count == ($clog2(LAP_DEPTH+1))'(LAP_DEPTH));
    assign do_pop    = lap_valid && lap_ready && !clear;
    assign do_push   = lap && !clear && (!full || do_pop);
    assign lap_data  = lap_valid ? lap_mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (do_push) lap_mem[wr_ptr] <= time_bcd;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            lap_count <= '0;
            lap_ovf   <= 1'b0;
        end else if (clear) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            lap_count <= '0;
            lap_ovf   <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            if (do_push && !do_pop)
                lap_count <= lap_count + 1'b1;
            else if (do_pop && !do_push)
                lap_count <= lap_count - 1'b1;
            if (lap && full && !do_pop)
                lap_ovf <= 1'b1;
        end
    end

endmodule
